// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator; define VGA_TIMING_LINE_IRQ_EN to add the line-compare interrupt
module vga_timing_gen #(
    parameter int H_DISP  = 1280,
    parameter int H_FRONT = 48,
    parameter int H_SYNC  = 112,
    parameter int H_BACK  = 248,
    parameter int V_DISP  = 1024,
    parameter int V_FRONT = 1,
    parameter int V_SYNC  = 3,
    parameter int V_BACK  = 38,
    parameter int H_POL   = 1,
    parameter int V_POL   = 1,
    parameter int CW      = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
`ifdef VGA_TIMING_LINE_IRQ_EN
    input  logic [CW-1:0] i_irq_line,
    output logic          o_line_irq,
`endif
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_disp,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start
);
    localparam int   H_TOT  = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOT  = V_DISP + V_FRONT + V_SYNC + V_BACK;
    localparam int   HS_BEG = H_DISP + H_FRONT;
    localparam int   HS_END = HS_BEG + H_SYNC;
    localparam int   VS_BEG = V_DISP + V_FRONT;
    localparam int   VS_END = VS_BEG + V_SYNC;
    localparam logic H_ACT  = (H_POL != 0);
    localparam logic V_ACT  = (V_POL != 0);

    if (H_DISP == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_DISP == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
        H_TOT > 2 ** CW || V_TOT > 2 ** CW) begin : g_bad_cfg
        $error("vga_timing_gen: zero timing parameter or total exceeds 2**CW");
    end

    logic [CW-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic          h_wrap, v_wrap, disp_nxt, hs_nxt, vs_nxt;

    // next raster position and the output levels it decodes to
    always_comb begin
        h_wrap   = int'(h_cnt) == H_TOT - 1;
        v_wrap   = h_wrap && int'(v_cnt) == V_TOT - 1;
        h_nxt    = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt    = v_wrap ? '0 : (h_wrap ? v_cnt + 1'b1 : v_cnt);
        disp_nxt = int'(h_nxt) < H_DISP && int'(v_nxt) < V_DISP;
        hs_nxt   = (int'(h_nxt) >= HS_BEG && int'(h_nxt) < HS_END) ? H_ACT : ~H_ACT;
        vs_nxt   = (int'(v_nxt) >= VS_BEG && int'(v_nxt) < VS_END) ? V_ACT : ~V_ACT;
    end

    // counters and registered outputs advance together so outputs match the held position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_disp        <= 1'b1;
            o_x           <= '0;
            o_y           <= '0;
            o_hsync       <= ~H_ACT;
            o_vsync       <= ~V_ACT;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            o_disp        <= disp_nxt;
            o_x           <= disp_nxt ? h_nxt : '0;
            o_y           <= disp_nxt ? v_nxt : '0;
            o_hsync       <= hs_nxt;
            o_vsync       <= vs_nxt;
            o_line_start  <= h_wrap;
            o_frame_start <= v_wrap;
        end else begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_LINE_IRQ_EN
    // strobe on the line-start edge entering the requested line; out-of-range lines never match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_line_irq <= 1'b0;
        else        o_line_irq <= i_en && h_wrap && v_nxt == i_irq_line;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: vector table, corner sequences and random enable run against a position-count model
module tb_vga_timing_gen;
    localparam int HT = 14, VT = 8, CW = 12;

    typedef struct {
        int steps;
        bit disp;
        int x, y;
        bit hs, vs, ls, fs;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0, i_en = 1'b0;
    logic          o_hsync, o_vsync, o_disp, o_line_start, o_frame_start;
    logic [CW-1:0] o_x, o_y;
`ifdef VGA_TIMING_LINE_IRQ_EN
    logic [CW-1:0] i_irq_line = '0;
    logic          o_line_irq;
`endif

    int checks = 0, failures = 0;
    int p = 0;
    bit ls_e = 0, fs_e = 0, irq_e = 0;
    vec_t vt[14];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_POL(0), .V_POL(0), .CW(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_en(i_en),
`ifdef VGA_TIMING_LINE_IRQ_EN
        .i_irq_line(i_irq_line),
        .o_line_irq(o_line_irq),
`endif
        .o_hsync(o_hsync),
        .o_vsync(o_vsync),
        .o_disp(o_disp),
        .o_x(o_x),
        .o_y(o_y),
        .o_line_start(o_line_start),
        .o_frame_start(o_frame_start)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input bit d, input int x, input int y,
                                input bit hs, input bit vs, input bit ls, input bit fs);
        vec_t v;
        v.steps = s; v.disp = d; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
        return v;
    endfunction

    // model: the raster position is simply the enabled-edge count modulo the frame size
    task automatic check_model(input string nm);
        int  h, v;
        bit  d;
        h = p % HT;
        v = p / HT;
        d = h < 8 && v < 4;
        cmp({nm, ".disp"}, 32'(o_disp), 32'(d));
        cmp({nm, ".x"}, 32'(o_x), d ? h : 0);
        cmp({nm, ".y"}, 32'(o_y), d ? v : 0);
        cmp({nm, ".hs"}, 32'(o_hsync), 32'(!(h >= 10 && h <= 12)));
        cmp({nm, ".vs"}, 32'(o_vsync), 32'(!(v >= 5 && v <= 6)));
        cmp({nm, ".ls"}, 32'(o_line_start), 32'(ls_e));
        cmp({nm, ".fs"}, 32'(o_frame_start), 32'(fs_e));
`ifdef VGA_TIMING_LINE_IRQ_EN
        cmp({nm, ".irq"}, 32'(o_line_irq), 32'(irq_e));
`endif
    endtask

    task automatic check_reset_vals(input string nm);
        cmp({nm, ".disp"}, 32'(o_disp), 1);
        cmp({nm, ".x"}, 32'(o_x), 0);
        cmp({nm, ".y"}, 32'(o_y), 0);
        cmp({nm, ".hs"}, 32'(o_hsync), 1);
        cmp({nm, ".vs"}, 32'(o_vsync), 1);
        cmp({nm, ".ls"}, 32'(o_line_start), 0);
        cmp({nm, ".fs"}, 32'(o_frame_start), 0);
`ifdef VGA_TIMING_LINE_IRQ_EN
        cmp({nm, ".irq"}, 32'(o_line_irq), 0);
`endif
    endtask

    task automatic tick(input bit en);
        i_en = en;
        @(posedge clk);
        #1;
        if (en) begin
            p    = (p + 1) % (HT * VT);
            ls_e = (p % HT) == 0;
            fs_e = p == 0;
`ifdef VGA_TIMING_LINE_IRQ_EN
            irq_e = ls_e && (p / HT) == int'(i_irq_line);
`endif
        end else begin
            ls_e = 0; fs_e = 0; irq_e = 0;
        end
    endtask

    task automatic do_reset();
        i_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        p = 0; ls_e = 0; fs_e = 0; irq_e = 0;
    endtask

    task automatic periods(input string nm, input bit alt, input int n,
                           input int exp_ls, input int exp_fs, input int exp_vs);
        int last_ls = -1, ls_gap = -1, last_fs = -1, fs_gap = -1, vs_low = 0, wide = 0;
        bit prev = 0;
        do_reset();
        for (int k = 1; k <= n; k++) begin
            tick(alt ? (k % 2 == 1) : 1'b1);
            check_model(nm);
            if (o_line_start) begin
                if (last_ls >= 0) ls_gap = k - last_ls;
                last_ls = k;
            end
            if (o_frame_start) begin
                if (last_fs >= 0) fs_gap = k - last_fs;
                last_fs = k;
            end
            if (k <= n / 2 && !o_vsync) vs_low++;
            if (o_line_start && prev) wide++;
            prev = o_line_start;
        end
        cmp({nm, ".ls_period"}, ls_gap, exp_ls);
        cmp({nm, ".fs_period"}, fs_gap, exp_fs);
        cmp({nm, ".vs_low_clks"}, vs_low, exp_vs);
        cmp({nm, ".ls_wide"}, wide, 0);
    endtask

`ifdef VGA_TIMING_LINE_IRQ_EN
    task automatic irq_frame(input int line, input int exp_cnt);
        int cnt = 0;
        i_irq_line = CW'(line);
        do_reset();
        repeat (HT * VT) begin
            tick(1'b1);
            check_model("irq");
            if (o_line_irq) cnt++;
        end
        cmp("irq_count", cnt, exp_cnt);
    endtask
`endif

    initial begin
        int n;
        vt[0]  = mk(0,   1, 0, 0, 1, 1, 0, 0);
        vt[1]  = mk(7,   1, 7, 0, 1, 1, 0, 0);
        vt[2]  = mk(8,   0, 0, 0, 1, 1, 0, 0);
        vt[3]  = mk(10,  0, 0, 0, 0, 1, 0, 0);
        vt[4]  = mk(12,  0, 0, 0, 0, 1, 0, 0);
        vt[5]  = mk(13,  0, 0, 0, 1, 1, 0, 0);
        vt[6]  = mk(14,  1, 0, 1, 1, 1, 1, 0);
        vt[7]  = mk(19,  1, 5, 1, 1, 1, 0, 0);
        vt[8]  = mk(49,  1, 7, 3, 1, 1, 0, 0);
        vt[9]  = mk(58,  0, 0, 0, 1, 1, 0, 0);
        vt[10] = mk(70,  0, 0, 0, 1, 0, 1, 0);
        vt[11] = mk(95,  0, 0, 0, 0, 0, 0, 0);
        vt[12] = mk(101, 0, 0, 0, 1, 1, 0, 0);
        vt[13] = mk(112, 1, 0, 0, 1, 1, 1, 1);

        i_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("hold_rst");

        foreach (vt[i]) begin
            do_reset();
            repeat (vt[i].steps) tick(1'b1);
            cmp($sformatf("vec%0d.disp", vt[i].steps), 32'(o_disp), 32'(vt[i].disp));
            cmp($sformatf("vec%0d.x", vt[i].steps), 32'(o_x), vt[i].x);
            cmp($sformatf("vec%0d.y", vt[i].steps), 32'(o_y), vt[i].y);
            cmp($sformatf("vec%0d.hs", vt[i].steps), 32'(o_hsync), 32'(vt[i].hs));
            cmp($sformatf("vec%0d.vs", vt[i].steps), 32'(o_vsync), 32'(vt[i].vs));
            cmp($sformatf("vec%0d.ls", vt[i].steps), 32'(o_line_start), 32'(vt[i].ls));
            cmp($sformatf("vec%0d.fs", vt[i].steps), 32'(o_frame_start), 32'(vt[i].fs));
        end

        periods("const_en", 1'b0, 2 * HT * VT, HT, HT * VT, 28);
        periods("alt_en", 1'b1, 4 * HT * VT, 2 * HT, 2 * HT * VT, 56);

        do_reset();
        repeat (2 * HT + 9) tick(1'b1);
        check_model("pre_rst");
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        p = 0; ls_e = 0; fs_e = 0; irq_e = 0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            tick(1'b1);
            n++;
        end while (!o_line_start && n < 40);
        cmp("rst_first_ls_edges", n, HT);

`ifdef VGA_TIMING_LINE_IRQ_EN
        irq_frame(3, 1);
        irq_frame(9, 0);
        irq_frame(0, 1);
`endif

        do_reset();
        for (int k = 0; k < 600; k++) begin
`ifdef VGA_TIMING_LINE_IRQ_EN
            if (k % 50 == 0) i_irq_line = CW'($urandom_range(0, 9));
`endif
            tick($urandom_range(0, 3) != 0);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
